// File: rtl/uart_receiver.sv
// UART receive path: 8N1 frames, oversampled at CLKS_PER_BIT clocks per bit,
// sampled mid-bit, one-byte holding register with ack/overrun handshake.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       UART_RX,
   input  logic       RX_ACK,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       RX_FRAME_ERR,
   output logic       RX_OVERRUN,
   output logic       RX_STATUS
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic             sync_p0;
   logic             sync_p1;
   logic [7:0]       shreg;

   // Mid-bit sample strobe for a data bit; the shift register is pure datapath.
   always_ff @(posedge sysclk) begin
      if (state == DATA && cnt == CNT_LAST) begin
         shreg[bit_idx] <= sync_p1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync_p0      <= 1'b1;
         sync_p1      <= 1'b1;
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         RX_DATA      <= '0;
         RX_VALID     <= 1'b0;
         RX_FRAME_ERR <= 1'b0;
         RX_OVERRUN   <= 1'b0;
      end else begin
         // Stage p0 -> p1: two-flop synchronizer on the asynchronous pin
         sync_p0      <= UART_RX;
         sync_p1      <= sync_p0;
         RX_FRAME_ERR <= 1'b0;
         if (RX_ACK) begin
            RX_VALID   <= 1'b0;
            RX_OVERRUN <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!sync_p1) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_MID) begin
                  if (sync_p1) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     cnt     <= '0;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (sync_p1) begin
                     // Leave mid-stop so a following start edge is not missed.
                     state <= IDLE;
                     if (!RX_VALID || RX_ACK) begin
                        RX_DATA  <= shreg;
                        RX_VALID <= 1'b1;
                     end else begin
                        RX_OVERRUN <= 1'b1;
                     end
                  end else begin
                     RX_FRAME_ERR <= 1'b1;
                     state        <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            WAIT_IDLE: begin
               if (sync_p1) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign RX_STATUS = (state == IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a byte-level holding-register model.
module tb_uart_receiver;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int LAT  = 2 + HALF + 9 * CPB + 1;

   logic       sysclk  = 1'b0;
   logic       reset   = 1'b1;
   logic       UART_RX = 1'b1;
   logic       RX_ACK  = 1'b0;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       RX_FRAME_ERR;
   logic       RX_OVERRUN;
   logic       RX_STATUS;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .UART_RX     (UART_RX),
      .RX_ACK      (RX_ACK),
      .RX_DATA     (RX_DATA),
      .RX_VALID    (RX_VALID),
      .RX_FRAME_ERR(RX_FRAME_ERR),
      .RX_OVERRUN  (RX_OVERRUN),
      .RX_STATUS   (RX_STATUS)
   );

   always #5 sysclk = ~sysclk;

   int   cyc      = 0;
   int   rise_cyc = -1;
   int   ferr_cnt = 0;
   logic valid_q  = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   logic [7:0] md;
   logic       mv;
   logic       mo;

   always @(posedge sysclk) cyc++;

   always @(negedge sysclk) begin
      if (RX_VALID === 1'b1 && valid_q !== 1'b1) rise_cyc = cyc;
      valid_q = RX_VALID;
      if (RX_FRAME_ERR === 1'b1) ferr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   // Byte-level view: a good frame either fills the register or flags overrun.
   task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack);
      if (stop) begin
         if (!mv || ack) begin
            md = b;
            mv = 1'b1;
            if (ack) mo = 1'b0;
         end else begin
            mo = 1'b1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".data"},    RX_DATA,    md);
      chk({tag, ".valid"},   RX_VALID,   mv);
      chk({tag, ".overrun"}, RX_OVERRUN, mo);
      chk({tag, ".status"},  RX_STATUS,  1'b1);
   endtask

   task automatic do_ack();
      RX_ACK = 1'b1;
      tick(1);
      RX_ACK = 1'b0;
      mv = 1'b0;
      mo = 1'b0;
   endtask

   // Called just after a posedge; each bit is held for CPB clocks.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_commit);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         UART_RX = bits[i];
         for (int k = 1; k <= CPB; k++) begin
            tick(1);
            if (ack_commit && i == 9) RX_ACK = (k == HALF + 2);
         end
      end
   endtask

   initial begin
      int         start_cyc;
      int         f0;
      logic [7:0] b;
      logic       stop;
      logic       ackc;
      logic [7:0] partial;

      tick(3);
      chk("rst.data",    RX_DATA,      8'h00);
      chk("rst.valid",   RX_VALID,     1'b0);
      chk("rst.ferr",    RX_FRAME_ERR, 1'b0);
      chk("rst.overrun", RX_OVERRUN,   1'b0);
      chk("rst.status",  RX_STATUS,    1'b1);
      reset = 1'b0;
      md = 8'h00;
      mv = 1'b0;
      mo = 1'b0;
      tick(4);

      // 1: single frame, latency from pin fall to RX_VALID
      start_cyc = cyc;
      f0 = ferr_cnt;
      send_frame(8'hA5, 1'b1, 1'b0);
      model_frame(8'hA5, 1'b1, 1'b0);
      chk("t1.latency", rise_cyc - start_cyc, LAT);
      check_outputs("t1");
      chk("t1.ferr", ferr_cnt - f0, 0);

      // 2: short low glitch is rejected as a false start
      do_ack();
      tick(4);
      UART_RX = 1'b0;
      tick(5);
      chk("t2.status_busy", RX_STATUS, 1'b0);
      UART_RX = 1'b1;
      tick(20);
      check_outputs("t2");

      // 3: bad stop bit, held-low line, then recovery
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 1'b0);
      chk("t3.ferr_pulses", ferr_cnt - f0, 1);
      tick(20);
      chk("t3.wait_status", RX_STATUS, 1'b0);
      chk("t3.valid", RX_VALID, 1'b0);
      UART_RX = 1'b1;
      tick(4);
      chk("t3.idle_status", RX_STATUS, 1'b1);
      send_frame(8'h11, 1'b1, 1'b0);
      model_frame(8'h11, 1'b1, 1'b0);
      check_outputs("t3b");

      // 4: back-to-back frames, second acked on its commit cycle
      do_ack();
      tick(2);
      send_frame(8'h00, 1'b1, 1'b0);
      model_frame(8'h00, 1'b1, 1'b0);
      check_outputs("t4a");
      send_frame(8'hFF, 1'b1, 1'b1);
      model_frame(8'hFF, 1'b1, 1'b1);
      check_outputs("t4b");
      do_ack();
      check_outputs("t4c");

      // 5: overrun
      send_frame(8'h12, 1'b1, 1'b0);
      model_frame(8'h12, 1'b1, 1'b0);
      send_frame(8'h34, 1'b1, 1'b0);
      model_frame(8'h34, 1'b1, 1'b0);
      check_outputs("t5a");
      do_ack();
      check_outputs("t5b");

      // 6: reset in the middle of bit 4
      send_frame(8'h21, 1'b1, 1'b0);
      model_frame(8'h21, 1'b1, 1'b0);
      partial = 8'h5A;
      UART_RX = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         UART_RX = partial[i];
         tick(CPB);
      end
      UART_RX = partial[4];
      tick(HALF);
      reset = 1'b1;
      UART_RX = 1'b1;
      tick(2);
      reset = 1'b0;
      md = 8'h00;
      mv = 1'b0;
      mo = 1'b0;
      check_outputs("t6rst");
      chk("t6rst.ferr", RX_FRAME_ERR, 1'b0);
      tick(CPB * 8);
      check_outputs("t6idle");
      send_frame(8'h77, 1'b1, 1'b0);
      model_frame(8'h77, 1'b1, 1'b0);
      check_outputs("t6b");

      // Randomized frames, acks and stop-bit errors
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 1) == 1) do_ack();
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 5) != 0);
         ackc = stop && ($urandom_range(0, 3) == 0);
         f0   = ferr_cnt;
         send_frame(b, stop, ackc);
         model_frame(b, stop, ackc);
         UART_RX = 1'b1;
         tick(3);
         check_outputs("rnd");
         chk("rnd.ferr", ferr_cnt - f0, stop ? 0 : 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
